// File: rtl/min_os_pkg.sv
// Shared definitions for the MinOS board scheduler and its UART peer.
// Holds the chunk type codes both ends agree on and the 3-bit state
// encoding of the peer's switch-report TX sequencer.
package min_os_pkg;

  localparam logic [7:0] LEDS_CHUNK_TYPE     = 8'd2;
  localparam logic [7:0] SWITCHES_CHUNK_TYPE = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_e;

endpackage

// File: rtl/sync_change_detect.sv
// Multi-flop synchronizer for an asynchronous bus plus a comparator
// against a caller-held reference value.
//   CLK, RST_N  : clock / async active-low reset
//   d_async     : raw asynchronous input bus
//   ref_val     : value to compare the synchronized bus against
//   sync_out    : last synchronizer stage
//   sync_valid  : high once the pipe holds real samples (reset zeros flushed)
//   changed     : sync_out != ref_val
module sync_change_detect #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] d_async,
  input  logic [W-1:0] ref_val,
  output logic [W-1:0] sync_out,
  output logic         sync_valid,
  output logic         changed
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_pipe;
  // Tracks how many real samples have entered the pipe since reset, so a
  // consumer never acts on the zeros the reset left behind.
  logic [SYNC_STAGES-1:0]        vld_pipe;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_pipe <= '0;
      vld_pipe  <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d_async};
      vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_out   = sync_pipe[SYNC_STAGES-1];
  assign sync_valid = vld_pipe[SYNC_STAGES-1];
  assign changed    = (sync_pipe[SYNC_STAGES-1] != ref_val);

endmodule

// File: rtl/min_os_peer.sv
// Chunk-level peer of the MinOS board scheduler.
//   RX: "leds" chunks (type LEDS_RX_CHUNK_TYPE, size 1) drive leds_out;
//       any other chunk is dropped and counted (saturating at 255).
//   TX: synchronized switch changes are reported as one-byte "switches"
//       chunks through a LOAD/RELEASE/WAIT/GAP handshake with the TX
//       chunker, with a timeout that forces a resend.
// Ports:
//   CLK, RST_N                      clock / async active-low reset
//   rx_chunk_*, rx_is_chunk_ready   incoming chunk from the RX chunker
//   tx_chunk_*, tx_is_chunk_ready   outgoing chunk to the TX chunker
//   is_tx_chunker_done              TX chunker completion strobe
//   switches_in / leds_out          physical I/O
//   rx_drop_count, tx_busy          status
module min_os_peer
  import min_os_pkg::*;
#(
  parameter logic [7:0] LEDS_RX_CHUNK_TYPE           = LEDS_CHUNK_TYPE,
  parameter logic [7:0] SWITCHES_TX_CHUNK_TYPE       = SWITCHES_CHUNK_TYPE,
  parameter int         RX_CONTENT_BUFFER_BYTE_SIZE  = 5,
  parameter int         RX_CONTENT_BUFFER_INDEX_SIZE = 32,
  parameter int         TX_CONTENT_BUFFER_BYTE_SIZE  = 3,
  parameter int         TX_CONTENT_BUFFER_INDEX_SIZE = 32,
  parameter int         TX_TIMEOUT_CYCLES            = 1000000
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic [7:0]                               rx_chunk_type,
  input  logic [RX_CONTENT_BUFFER_BYTE_SIZE*8-1:0] rx_chunk_bytes,
  input  logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0]  rx_chunk_byte_size,
  input  logic                                     rx_is_chunk_ready,
  output logic                                     tx_is_chunk_ready,
  output logic [7:0]                               tx_chunk_type,
  output logic [TX_CONTENT_BUFFER_INDEX_SIZE-1:0]  tx_chunk_byte_size,
  output logic [TX_CONTENT_BUFFER_BYTE_SIZE*8-1:0] tx_chunk_bytes,
  input  logic                                     is_tx_chunker_done,
  input  logic [7:0]                               switches_in,
  output logic [7:0]                               leds_out,
  output logic [7:0]                               rx_drop_count,
  output logic                                     tx_busy
);

  localparam int CNT_W = $clog2(TX_TIMEOUT_CYCLES) + 1;

  tx_state_e        state_q, state_d;
  logic [7:0]       sw_sync, last_sent, sent_bytes_q;
  logic             sync_valid, sw_changed, boot_pending, sent_once, timeout;
  logic [CNT_W-1:0] to_cnt;
  logic             rx_leds_ok;
  logic             rx_unused;

  sync_change_detect #(.W(8), .SYNC_STAGES(2)) u_sync (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .d_async   (switches_in),
    .ref_val   (last_sent),
    .sync_out  (sw_sync),
    .sync_valid(sync_valid),
    .changed   (sw_changed)
  );

  // ---------------- TX sequencer ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      // Boot report waits for the synchronizer to hold a real sample so
      // the first chunk carries the actual switch state, not reset zeros.
      ST_IDLE:    if (sync_valid && (boot_pending || sw_changed)) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (is_tx_chunker_done) begin
          state_d = ST_GAP;
        end else if (to_cnt == CNT_W'(TX_TIMEOUT_CYCLES - 1)) begin
          state_d = ST_GAP;
          timeout = 1'b1;
        end
      end
      ST_GAP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_sent    <= '0;
      sent_bytes_q <= '0;
      boot_pending <= 1'b1;
      sent_once    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      if (state_q == ST_LOAD) begin
        last_sent    <= sw_sync;
        sent_bytes_q <= sw_sync;
        boot_pending <= 1'b0;
        sent_once    <= 1'b1;
        to_cnt       <= '0;
      end else if (state_q == ST_WAIT) begin
        to_cnt <= to_cnt + 1'b1;
        // An abandoned send is retried with whatever the switches read then.
        if (timeout) boot_pending <= 1'b1;
      end
    end
  end

  // Type and payload hold their last sent values between sends; only LOAD
  // presents the live synchronized value.
  always_comb begin
    tx_is_chunk_ready  = (state_q == ST_LOAD);
    tx_chunk_byte_size = (state_q == ST_LOAD) ? TX_CONTENT_BUFFER_INDEX_SIZE'(1) : '0;
    tx_chunk_type      = ((state_q == ST_LOAD) || sent_once) ? SWITCHES_TX_CHUNK_TYPE : 8'h00;
    tx_chunk_bytes     = '0;
    tx_chunk_bytes[7:0] = (state_q == ST_LOAD) ? sw_sync : sent_bytes_q;
  end

  assign tx_busy = (state_q != ST_IDLE);

  // ---------------- RX path ----------------
  assign rx_leds_ok = (rx_chunk_type == LEDS_RX_CHUNK_TYPE) &&
                      (rx_chunk_byte_size == RX_CONTENT_BUFFER_INDEX_SIZE'(1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      leds_out      <= '0;
      rx_drop_count <= '0;
    end else if (rx_is_chunk_ready) begin
      if (rx_leds_ok)                  leds_out      <= rx_chunk_bytes[7:0];
      else if (rx_drop_count != 8'hFF) rx_drop_count <= rx_drop_count + 1'b1;
    end
  end

  // Only byte 0 of the RX payload carries LED state.
  assign rx_unused = ^rx_chunk_bytes[RX_CONTENT_BUFFER_BYTE_SIZE*8-1:8];

endmodule

// File: tb/tb_min_os_peer.sv
// Scoreboard bench for min_os_peer: stimulus pushes expected TX reports and
// RX outcomes into queues; monitors pop and compare when the DUT presents them.
module tb_min_os_peer;

  localparam int RXB = 5, TXB = 3, TO = 50;

  logic            CLK = 1'b0, RST_N = 1'b0;
  logic [7:0]      rx_chunk_type = '0;
  logic [RXB*8-1:0] rx_chunk_bytes = '0;
  logic [31:0]     rx_chunk_byte_size = '0;
  logic            rx_is_chunk_ready = 1'b0;
  logic            tx_is_chunk_ready;
  logic [7:0]      tx_chunk_type;
  logic [31:0]     tx_chunk_byte_size;
  logic [TXB*8-1:0] tx_chunk_bytes;
  logic            is_tx_chunker_done;
  logic            resp_done = 1'b0, force_done = 1'b0;
  logic [7:0]      switches_in = '0;
  logic [7:0]      leds_out, rx_drop_count;
  logic            tx_busy;

  assign is_tx_chunker_done = resp_done | force_done;

  always #5 CLK = ~CLK;

  min_os_peer #(
    .RX_CONTENT_BUFFER_BYTE_SIZE(RXB), .TX_CONTENT_BUFFER_BYTE_SIZE(TXB),
    .TX_TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .rx_chunk_type(rx_chunk_type), .rx_chunk_bytes(rx_chunk_bytes),
    .rx_chunk_byte_size(rx_chunk_byte_size), .rx_is_chunk_ready(rx_is_chunk_ready),
    .tx_is_chunk_ready(tx_is_chunk_ready), .tx_chunk_type(tx_chunk_type),
    .tx_chunk_byte_size(tx_chunk_byte_size), .tx_chunk_bytes(tx_chunk_bytes),
    .is_tx_chunker_done(is_tx_chunker_done), .switches_in(switches_in),
    .leds_out(leds_out), .rx_drop_count(rx_drop_count), .tx_busy(tx_busy)
  );

  typedef struct packed { logic [7:0] leds; logic [7:0] drop; } rx_exp_t;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, last_strobe = 0, last_gap = 0;
  bit          have_strobe = 0, rx_prev = 0;
  int          done_delay = 4;
  logic [7:0]  tx_q[$];
  rx_exp_t     rx_q[$];
  // reference model state
  logic [7:0]  m_leds = 0, m_drop = 0, m_last = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++; n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic tick; @(posedge CLK); #1; endtask

  // A report is due after reset, or whenever the switches differ from the last report.
  task automatic expect_tx(input logic [7:0] v);
    tx_q.push_back(v);
    m_last = v;
  endtask

  task automatic send_rx(input logic [7:0] ty, input logic [31:0] sz, input logic [RXB*8-1:0] b);
    rx_chunk_type = ty; rx_chunk_byte_size = sz; rx_chunk_bytes = b; rx_is_chunk_ready = 1'b1;
    if (ty == 8'd2 && sz == 32'd1) m_leds = b[7:0];
    else if (m_drop < 8'd255)     m_drop = m_drop + 8'd1;
    rx_q.push_back('{leds: m_leds, drop: m_drop});
    tick;
    rx_is_chunk_ready = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int k = 0;
    while (!tx_is_chunk_ready && k < 300) begin tick; k++; end
    if (k >= 300) bound_fail(name);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((tx_q.size() != 0 || tx_busy) && k < 400) begin tick; k++; end
    if (k >= 400) bound_fail(name);
    repeat (6) tick;
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // TX monitor: every strobe must match the oldest expected report.
  always @(negedge CLK) begin
    if (!RST_N) begin
      have_strobe = 0;
    end else if (tx_is_chunk_ready) begin
      if (tx_q.size() == 0) begin
        bound_fail("tx_unexpected_chunk");
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        check("tx_type", tx_chunk_type, 8'd4);
        check("tx_size", tx_chunk_byte_size, 1);
        check("tx_bytes", tx_chunk_bytes, {16'h0, e});
      end
      if (have_strobe) begin
        last_gap = cyc - last_strobe;
        check("tx_strobe_gap_ge4", (cyc - last_strobe) >= 4, 1);
      end
      have_strobe = 1;
      last_strobe = cyc;
    end
  end

  // RX monitor: outcome of a chunk is checked the cycle after its strobe.
  always @(negedge CLK) begin
    if (!RST_N) begin
      rx_prev = 0;
    end else begin
      if (rx_prev) begin
        if (rx_q.size() == 0) bound_fail("rx_queue_underflow");
        else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          check("rx_leds", leds_out, e.leds);
          check("rx_drop", rx_drop_count, e.drop);
        end
      end
      rx_prev = rx_is_chunk_ready;
    end
  end

  // TX chunker stand-in: answers each strobe after done_delay cycles (<0 = never).
  initial forever begin
    @(negedge CLK);
    if (RST_N && tx_is_chunk_ready && done_delay >= 2) begin
      repeat (done_delay) @(posedge CLK);
      #1 resp_done = 1'b1;
      @(posedge CLK);
      #1 resp_done = 1'b0;
    end
  end

  initial begin
    logic [7:0] v;
    int g0;
    // ---- reset with switches at A5 ----
    switches_in = 8'hA5;
    done_delay  = 20;
    repeat (3) tick;
    check("reset_outputs",
          {tx_is_chunk_ready, tx_chunk_type, tx_chunk_byte_size, tx_chunk_bytes, leds_out, rx_drop_count, tx_busy},
          '0);
    expect_tx(8'hA5);
    RST_N = 1'b1;
    drain("boot_report");
    check("boot_busy_low", tx_busy, 0);

    // ---- done while idle is ignored ----
    force_done = 1'b1; tick; force_done = 1'b0; tick;
    check("done_idle_no_busy", tx_busy, 0);

    // ---- RX: good, bad size, unknown type, echo, saturation ----
    send_rx(8'd2, 32'd1, 40'h11_22_33_44_3C);
    send_rx(8'd2, 32'd2, 40'h00_00_00_00_77);
    send_rx(8'd7, 32'd1, 40'h00_00_00_00_66);
    send_rx(8'd4, 32'd1, 40'h00_00_00_00_55);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ty;
      logic [31:0] sz;
      ty = 8'($urandom_range(0, 255));
      sz = 32'($urandom_range(0, 4));
      if (ty == 8'd2 && sz == 32'd1) sz = 32'd3;
      send_rx(ty, sz, {$urandom, 8'($urandom)});
    end
    tick;
    check("rx_drop_saturated", rx_drop_count, 8'hFF);
    check("rx_leds_held", leds_out, 8'h3C);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ty;
      ty = ($urandom_range(0, 1) != 0) ? 8'd2 : 8'($urandom_range(0, 255));
      send_rx(ty, 32'($urandom_range(0, 2)), {$urandom, 8'($urandom)});
    end
    tick;

    // ---- coalescing: 00 -> 11, then 22, 33 during WAIT ----
    done_delay = 8;
    switches_in = 8'h00; expect_tx(8'h00);
    drain("sw_00");
    done_delay = 30;
    switches_in = 8'h11; expect_tx(8'h11);
    wait_strobe("sw_11_strobe");
    repeat (4) tick;
    switches_in = 8'h22; repeat (3) tick;
    switches_in = 8'h33; expect_tx(8'h33);
    drain("sw_coalesce");

    // ---- revert to last sent during WAIT produces no chunk ----
    switches_in = 8'h44; expect_tx(8'h44);
    wait_strobe("revert_strobe");
    repeat (4) tick;
    switches_in = 8'h99; repeat (4) tick;
    switches_in = 8'h44;
    drain("revert");

    // ---- LEDS chunk in the LOAD cycle ----
    done_delay = 6;
    switches_in = 8'h5A; expect_tx(8'h5A);
    wait_strobe("load_rx_strobe");
    send_rx(8'd2, 32'd1, {32'hDEAD_BEEF, 8'hC3});
    drain("load_rx");
    check("load_rx_leds", leds_out, 8'hC3);

    // ---- timeout forces a resend of the same value ----
    done_delay = -1;
    switches_in = 8'h6B; expect_tx(8'h6B);
    wait_strobe("timeout_first");
    g0 = cyc;
    tick;
    done_delay = 5;
    tx_q.push_back(8'h6B);
    drain("timeout_resend");
    check("timeout_gap_in_range", (last_gap >= TO) && (last_gap <= TO + 8), 1);
    check("timeout_resend_after_first", last_strobe > g0, 1);

    // ---- reset during WAIT ----
    done_delay = -1;
    switches_in = 8'h7E; expect_tx(8'h7E);
    wait_strobe("rst_wait_strobe");
    repeat (4) tick;
    RST_N = 1'b0;
    #1;
    check("reset_midsend_outputs",
          {tx_is_chunk_ready, tx_chunk_type, tx_chunk_byte_size, tx_chunk_bytes, leds_out, rx_drop_count, tx_busy},
          '0);
    m_leds = 0; m_drop = 0;
    expect_tx(8'h7E);
    repeat (3) tick;
    done_delay = 4;
    RST_N = 1'b1;
    drain("rst_boot_resend");

    // ---- randomized switch activity ----
    for (int i = 0; i < 14; i++) begin
      v = 8'($urandom_range(0, 3)) * 8'h21;
      done_delay = $urandom_range(2, 12);
      switches_in = v;
      if (v != m_last) expect_tx(v);
      drain("rand_sw");
    end

    check("tx_queue_empty", tx_q.size(), 0);
    check("rx_queue_empty", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/min_os_peer.md
Name: min_os_peer

Overview:
- Chunk-level counterpart of the board-side MinOS scheduler. It sits at the far end of the UART link, between a uart_rx_typed_chunker and a uart_tx_typed_chunker.
- It decodes incoming "leds" chunks (type 2) onto physical LED outputs.
- It reports physical switch changes as outgoing "switches" chunks (type 4).
- Two boards running min_os and min_os_peer form a closed loop: one board's LEDs mirror onto the peer, and the peer's switches drive the board.

Parameters:
- LEDS_RX_CHUNK_TYPE, 2, chunk type decoded into leds_out
- SWITCHES_TX_CHUNK_TYPE, 4, chunk type emitted for switch reports
- RX_CONTENT_BUFFER_BYTE_SIZE, 5, byte width of rx_chunk_bytes
- RX_CONTENT_BUFFER_INDEX_SIZE, 32, width of rx_chunk_byte_size
- TX_CONTENT_BUFFER_BYTE_SIZE, 3, byte width of tx_chunk_bytes
- TX_CONTENT_BUFFER_INDEX_SIZE, 32, width of tx_chunk_byte_size
- TX_TIMEOUT_CYCLES, 1000000, maximum wait for is_tx_chunker_done before abandoning a send

Ports:
- CLK  in  1  system clock; all logic on posedge
- RST_N  in  1  asynchronous active-low reset
- rx_chunk_type  in  8  type of received chunk
- rx_chunk_bytes  in  RX_CONTENT_BUFFER_BYTE_SIZE*8  received payload; byte 0 = [7:0]
- rx_chunk_byte_size  in  RX_CONTENT_BUFFER_INDEX_SIZE  valid payload bytes
- rx_is_chunk_ready  in  1  one-cycle strobe: chunk fields valid
- tx_is_chunk_ready  out  1  one-cycle strobe to TX chunker
- tx_chunk_type  out  8  outgoing chunk type
- tx_chunk_byte_size  out  TX_CONTENT_BUFFER_INDEX_SIZE  outgoing payload size
- tx_chunk_bytes  out  TX_CONTENT_BUFFER_BYTE_SIZE*8  outgoing payload
- is_tx_chunker_done  in  1  TX chunker finished strobe
- switches_in  in  8  raw asynchronous physical switches
- leds_out  out  8  decoded LED state
- rx_drop_count  out  8  saturating count of rejected chunks
- tx_busy  out  1  high in every state other than IDLE

Behaviour:
- Reset: while RST_N=0, all outputs are 0; the synchronizer is 0, last_sent=0, boot_pending=1, and the FSM is in IDLE. Reset mid-send aborts immediately, with no strobe completion.
- switches_in passes through a 2-flop synchronizer; sw_sync is the second stage.
- RX path (independent of the TX FSM, may coincide with it):
  - On rx_is_chunk_ready with type==LEDS_RX_CHUNK_TYPE and size==1: leds_out <= rx_chunk_bytes[7:0] on the same edge (visible the next cycle).
  - Matching type with size!=1, or any unknown type: leds_out is held and rx_drop_count increments, saturating at 255.
  - Chunks with type==SWITCHES_TX_CHUNK_TYPE (an echo) are also dropped.
- TX FSM states:
  - IDLE: if boot_pending or sw_sync!=last_sent, go to LOAD.
  - LOAD:
    - tx_is_chunk_ready=1, tx_chunk_type=SWITCHES_TX_CHUNK_TYPE, tx_chunk_byte_size=1.
    - tx_chunk_bytes[7:0]=sw_sync; upper bytes = 0.
    - last_sent<=sw_sync, boot_pending<=0, timeout counter cleared.
    - Go to RELEASE.
  - RELEASE: tx_is_chunk_ready=0, tx_chunk_byte_size=0; go to WAIT.
  - WAIT:
    - On is_tx_chunker_done, go to GAP.
    - When the counter reaches TX_TIMEOUT_CYCLES-1: boot_pending<=1 (forces a resend), go to GAP.
  - GAP: one cycle, then IDLE.
- is_tx_chunker_done is ignored outside WAIT.
- Switch changes during LOAD..GAP are not lost. IDLE re-compares and sends only the latest value (coalescing); a change reverting to last_sent produces no chunk.
- Strobe spacing: minimum 4 cycles between successive tx_is_chunk_ready pulses.
- tx_chunk_type and tx_chunk_bytes hold their last values between sends.

Decomposition:
- Shared package min_os_pkg holds the chunk-type constants (LEDS=2, SWITCHES=4), also used by min_os.
- Shared package also holds the FSM state encodings (3-bit: IDLE=0, LOAD=1, RELEASE=2, WAIT=3, GAP=4).
- One natural sub-module: sync_change_detect (2-flop synchronizer plus compare against a stored value).

Test Plan:
- Reset release with switches_in=8'hA5, then done after 20 cycles → exactly one chunk: type 4, size 1, bytes[7:0]=A5; tx_busy returns low.
- rx strobe with type 2, size 1, bytes=8'h3C → leds_out=3C one cycle later; rx_drop_count=0.
- rx with type 2, size 2; then type 7; then 300 bad chunks → leds_out unchanged; rx_drop_count 1, then 2, then saturates at 255.
- switches 00→11 and, during WAIT, 11→22→33 → two chunks total: payloads 11 then 33.
- Valid LEDS chunk arriving in the same cycle as LOAD → leds_out updates and the TX chunk is unaffected.
- Done never asserted → after TX_TIMEOUT_CYCLES (set to 50 in the bench) the same value is resent. RST_N low during WAIT → outputs 0 immediately; boot resend occurs after release.
